// File: rtl/reg_scoreboard_pkg.sv
// ============================================================================
// reg_scoreboard_pkg : shared sizing defaults and register-index type
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;
  localparam int NUM_REGS_DEF   = 16;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int CNT_W_DEF      = 2;

  typedef logic [REG_ADDR_W_DEF-1:0] reg_idx_t;
endpackage

`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// reg_scoreboard_if : pipeline-event / ID-operand bundle for the scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) ();
  logic                  freeze;
  logic                  issue_valid;
  logic                  issue_wb_en;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic                  issue_mem_read;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [REG_ADDR_W-1:0] src_1;
  logic [REG_ADDR_W-1:0] src_2;
  logic                  two_src;
  logic                  forwarding_mode;
  logic                  hazard_detected;
  logic [NUM_REGS-1:0]   pending_vec;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output freeze, issue_valid, issue_wb_en, issue_dest, issue_mem_read,
           wb_valid, wb_dest, src_1, src_2, two_src, forwarding_mode,
    input  hazard_detected, pending_vec, err_overflow, err_underflow
  );

  modport slave (
    input  freeze, issue_valid, issue_wb_en, issue_dest, issue_mem_read,
           wb_valid, wb_dest, src_1, src_2, two_src, forwarding_mode,
    output hazard_detected, pending_vec, err_overflow, err_underflow
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard_sb_counter.sv
// ============================================================================
// sb_counter : saturating up/down pending-write counter with sticky errors
// Revision: 1.0
// ============================================================================
`default_nettype none

module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  input  wire logic             dec,
  output logic [CNT_W-1:0]      count,
  output logic                  pending,
  output logic                  err_overflow,
  output logic                  err_underflow
);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Simultaneous inc and dec cancel, so neither boundary check applies.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (inc && !dec) begin
      if (cnt_q == c_cnt_max) ovf_d = 1'b1;
      else                    cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) unf_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
    pending_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign count         = cnt_q;
  assign pending       = pending_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : per-register in-flight write tracking and ID hazard output
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  wire logic        clk,
  input  wire logic        rst,
  reg_scoreboard_if.slave  sb
);
  localparam int c_addr_span = 2**REG_ADDR_W;

  logic                  inc_ev;
  logic                  dec_ev;
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;
  logic [NUM_REGS-1:0]   pend_vec;
  logic [NUM_REGS-1:0]   ovf_vec;
  logic [NUM_REGS-1:0]   unf_vec;
  logic [CNT_W-1:0]      cnt [NUM_REGS];
  logic [c_addr_span-1:0] busy_map;
  logic                  hazard;

  logic                  exe_valid_q, exe_valid_d;
  logic [REG_ADDR_W-1:0] exe_dest_q,  exe_dest_d;
  logic                  exe_load_q,  exe_load_d;

  assign inc_ev = sb.issue_valid & sb.issue_wb_en & ~sb.freeze;
  assign dec_ev = sb.wb_valid & ~sb.freeze;

  // Indices at or above NUM_REGS never match a decode slot, so their
  // events drop out and their busy_map entries stay zero.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign inc_vec[i] = inc_ev & (sb.issue_dest == REG_ADDR_W'(i));
    assign dec_vec[i] = dec_ev & (sb.wb_dest == REG_ADDR_W'(i));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk           (clk),
      .rst           (rst),
      .inc           (inc_vec[i]),
      .dec           (dec_vec[i]),
      .count         (cnt[i]),
      .pending       (pend_vec[i]),
      .err_overflow  (ovf_vec[i]),
      .err_underflow (unf_vec[i])
    );

    assign busy_map[i] = (cnt[i] != '0);
  end

  for (genvar i = NUM_REGS; i < c_addr_span; i++) begin : g_pad
    assign busy_map[i] = 1'b0;
  end

  always_comb begin
    exe_valid_d = exe_valid_q;
    exe_dest_d  = exe_dest_q;
    exe_load_d  = exe_load_q;
    if (!sb.freeze) begin
      exe_valid_d = sb.issue_valid & sb.issue_wb_en;
      exe_dest_d  = sb.issue_dest;
      exe_load_d  = sb.issue_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid_q <= 1'b0;
      exe_dest_q  <= '0;
      exe_load_q  <= 1'b0;
    end else begin
      exe_valid_q <= exe_valid_d;
      exe_dest_q  <= exe_dest_d;
      exe_load_q  <= exe_load_d;
    end
  end

  // With forwarding only a load still in EXE cannot supply its result in time.
  always_comb begin
    hazard = 1'b0;
    if (sb.forwarding_mode) begin
      hazard = exe_valid_q & exe_load_q &
               ((sb.src_1 == exe_dest_q) |
                (sb.two_src & (sb.src_2 == exe_dest_q)));
    end else begin
      hazard = busy_map[sb.src_1] | (sb.two_src & busy_map[sb.src_2]);
    end
  end

  assign sb.hazard_detected = hazard;
  assign sb.pending_vec     = pend_vec;
  assign sb.err_overflow    = |ovf_vec;
  assign sb.err_underflow   = |unf_vec;
endmodule

`default_nettype wire
